// File: rtl/rx_fifo_pkg.sv
// rtl/rx_fifo_pkg.sv - shared constants, pointer type and Gray-code helpers for the RX FIFO
package rx_fifo_pkg;

  localparam int RX_FIFO_DATA_W = 8;
  localparam int RX_FIFO_ADDR_W = 6;
  localparam int PTR_MAX_W      = 32;

  typedef logic [RX_FIFO_ADDR_W:0] ptr_t;

  // Helpers work on a wide word; callers zero-extend and cast the result back to pointer width.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// rtl/fifo_ptr_sync.sv - multi-stage flop chain carrying a Gray pointer into another clock domain
module fifo_ptr_sync #(
  parameter int WIDTH       = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] gray_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk_i or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign gray_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/rx_async_fifo.sv
// rtl/rx_async_fifo.sv - dual-clock Gray-pointer RX FIFO with thresholds, fill counts and sticky errors
// RX_FIFO_FWFT_EN selects first-word-fall-through reads instead of a 1-cycle registered read.
module rx_async_fifo
  import rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = RX_FIFO_DATA_W,
  parameter int ADDR_WIDTH  = RX_FIFO_ADDR_W,
  parameter int AFULL_TH    = 56,
  parameter int AEMPTY_TH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  readClock,
  input  logic                  n_rst,
  input  logic                  writeClock,
  input  logic                  w_enable,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   w_count,
  output logic                  overflow,
  input  logic                  r_enable,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   r_count,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  typedef logic [ADDR_WIDTH:0] ptr_w_t;
  localparam ptr_w_t AFULL_P  = ptr_w_t'(AFULL_TH);
  localparam ptr_w_t AEMPTY_P = ptr_w_t'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  ptr_w_t wbin_q, wbin_d, wgray_q, wgray_d, w_count_q, w_count_d, rq_gray, rq_bin;
  logic   full_q, full_d, overflow_q, overflow_d, wr_en;

  ptr_w_t rbin_q, rbin_d, rgray_q, rgray_d, r_count_q, r_count_d, wq_gray, wq_bin;
  logic   empty_q, empty_d, underflow_q, underflow_d, rd_fetch;
  logic [DATA_WIDTH-1:0] r_data_q;

  fifo_ptr_sync #(.WIDTH(ADDR_WIDTH + 1), .SYNC_STAGES(SYNC_STAGES)) u_sync_r2w (
    .clk_i (writeClock),
    .n_rst (n_rst),
    .gray_i(rgray_q),
    .gray_o(rq_gray)
  );

  fifo_ptr_sync #(.WIDTH(ADDR_WIDTH + 1), .SYNC_STAGES(SYNC_STAGES)) u_sync_w2r (
    .clk_i (readClock),
    .n_rst (n_rst),
    .gray_i(wgray_q),
    .gray_o(wq_gray)
  );

  // Write domain: full compares against the read pointer with its two top Gray bits inverted.
  always_comb begin
    wr_en      = w_enable && !full_q;
    wbin_d     = wbin_q + ptr_w_t'(wr_en);
    wgray_d    = ptr_w_t'(bin2gray(PTR_MAX_W'(wbin_d)));
    rq_bin     = ptr_w_t'(gray2bin(PTR_MAX_W'(rq_gray)));
    full_d     = (wgray_d == {~rq_gray[ADDR_WIDTH -: 2], rq_gray[ADDR_WIDTH-2:0]});
    w_count_d  = wbin_d - rq_bin;
    overflow_d = overflow_q;
    if (clr_err) overflow_d = 1'b0;
    if (w_enable && full_q) overflow_d = 1'b1;
  end

  always_ff @(posedge writeClock or negedge n_rst) begin
    if (!n_rst) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      full_q     <= 1'b0;
      w_count_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wbin_q     <= wbin_d;
      wgray_q    <= wgray_d;
      full_q     <= full_d;
      w_count_q  <= w_count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge writeClock) begin
    if (wr_en) mem[wbin_q[ADDR_WIDTH-1:0]] <= w_data;
  end

`ifdef RX_FIFO_FWFT_EN
  // empty_q tracks the memory; valid_q tracks the word parked on r_data.
  logic valid_q, valid_d;
  always_comb begin
    rd_fetch    = !empty_q && (!valid_q || r_enable);
    valid_d     = rd_fetch ? 1'b1 : (r_enable ? 1'b0 : valid_q);
    rbin_d      = rbin_q + ptr_w_t'(rd_fetch);
    rgray_d     = ptr_w_t'(bin2gray(PTR_MAX_W'(rbin_d)));
    wq_bin      = ptr_w_t'(gray2bin(PTR_MAX_W'(wq_gray)));
    empty_d     = (rgray_d == wq_gray);
    r_count_d   = wq_bin - rbin_d + ptr_w_t'(valid_d);
    underflow_d = underflow_q;
    if (clr_err) underflow_d = 1'b0;
    if (r_enable && !valid_q) underflow_d = 1'b1;
  end

  always_ff @(posedge readClock or negedge n_rst) begin
    if (!n_rst) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  assign empty        = !valid_q;
`else
  always_comb begin
    rd_fetch    = r_enable && !empty_q;
    rbin_d      = rbin_q + ptr_w_t'(rd_fetch);
    rgray_d     = ptr_w_t'(bin2gray(PTR_MAX_W'(rbin_d)));
    wq_bin      = ptr_w_t'(gray2bin(PTR_MAX_W'(wq_gray)));
    empty_d     = (rgray_d == wq_gray);
    r_count_d   = wq_bin - rbin_d;
    underflow_d = underflow_q;
    if (clr_err) underflow_d = 1'b0;
    if (r_enable && empty_q) underflow_d = 1'b1;
  end

  assign empty        = empty_q;
`endif

  always_ff @(posedge readClock or negedge n_rst) begin
    if (!n_rst) begin
      rbin_q      <= '0;
      rgray_q     <= '0;
      empty_q     <= 1'b1;
      r_count_q   <= '0;
      underflow_q <= 1'b0;
      r_data_q    <= '0;
    end else begin
      rbin_q      <= rbin_d;
      rgray_q     <= rgray_d;
      empty_q     <= empty_d;
      r_count_q   <= r_count_d;
      underflow_q <= underflow_d;
      if (rd_fetch) r_data_q <= mem[rbin_q[ADDR_WIDTH-1:0]];
    end
  end

  assign full         = full_q;
  assign almost_full  = (w_count_q >= AFULL_P);
  assign w_count      = w_count_q;
  assign overflow     = overflow_q;
  assign r_data       = r_data_q;
  assign almost_empty = (r_count_q <= AEMPTY_P);
  assign r_count      = r_count_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_rx_async_fifo.sv
// tb/tb_rx_async_fifo.sv - scoreboard bench for rx_async_fifo; honours RX_FIFO_FWFT_EN when defined
module tb_rx_async_fifo;

  logic       readClock = 1'b0;
  logic       writeClock = 1'b0;
  logic       n_rst = 1'b0;
  logic       w_enable = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic       r_enable = 1'b0;
  logic       clr_err = 1'b0;
  logic       full, almost_full, overflow, empty, almost_empty, underflow;
  logic [6:0] w_count, r_count;
  logic [7:0] r_data;

  int vectors = 0;
  int miscompares = 0;
  int nwr = 0;
  int nread = 0;
  int viol_full = 0;
  int viol_empty = 0;
  logic [7:0] sb [$];

  always #5 writeClock = ~writeClock;
  always #7 readClock  = ~readClock;

  rx_async_fifo dut (
    .readClock   (readClock),
    .n_rst       (n_rst),
    .writeClock  (writeClock),
    .w_enable    (w_enable),
    .w_data      (w_data),
    .full        (full),
    .almost_full (almost_full),
    .w_count     (w_count),
    .overflow    (overflow),
    .r_enable    (r_enable),
    .r_data      (r_data),
    .empty       (empty),
    .almost_empty(almost_empty),
    .r_count     (r_count),
    .underflow   (underflow),
    .clr_err     (clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_step(input logic en, input logic [7:0] d);
    @(negedge writeClock);
    w_enable = en;
    w_data   = d;
    if (full && w_count != 7'd64) viol_full++;
    if (en && !full) begin
      sb.push_back(d);
      nwr++;
    end
    @(posedge writeClock);
    #1;
    w_enable = 1'b0;
  endtask

  task automatic rd_step(input logic en, input string tag);
    logic was_empty;
    @(negedge readClock);
    was_empty = empty;
`ifndef RX_FIFO_FWFT_EN
    if (empty && r_count != 7'd0) viol_empty++;
`endif
`ifdef RX_FIFO_FWFT_EN
    if (en && !was_empty) begin
      if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      else chk(tag, 32'(r_data), 32'(sb.pop_front()));
    end
`endif
    r_enable = en;
    @(posedge readClock);
    #1;
    r_enable = 1'b0;
`ifndef RX_FIFO_FWFT_EN
    if (en && !was_empty) begin
      if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      else chk(tag, 32'(r_data), 32'(sb.pop_front()));
    end
`endif
    if (en && !was_empty) nread++;
  endtask

  task automatic pulse_clr();
    @(negedge writeClock);
    clr_err = 1'b1;
    @(posedge writeClock);
    @(posedge readClock);
    #1;
    clr_err = 1'b0;
  endtask

  task automatic wait_not_empty(input string tag);
    int n = 0;
    while (empty && n < 50) begin
      @(posedge readClock);
      #1;
      n++;
    end
    chk(tag, 32'(empty), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #40;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rdata", 32'(r_data), 32'd0);
    chk("rst_wcount", 32'(w_count), 32'd0);
    chk("rst_rcount", 32'(r_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_afull", 32'(almost_full), 32'd0);
    @(negedge writeClock);
    #2;
    n_rst = 1'b1;

    // Fill to full, tracking the almost-full threshold
    for (int i = 0; i < 64; i++) begin
      wr_step(1'b1, 8'(i));
      chk("fill_wcount", 32'(w_count), 32'(i + 1));
      chk("fill_afull", 32'(almost_full), (i + 1 >= 56) ? 32'd1 : 32'd0);
    end
    chk("fill_full", 32'(full), 32'd1);
    wr_step(1'b1, 8'hAA);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_wcount", 32'(w_count), 32'd64);
    chk("ovf_full", 32'(full), 32'd1);

    // Drain everything in order
    repeat (6) @(posedge readClock);
    #1;
    chk("drain_rcount", 32'(r_count), 32'd64);
    chk("drain_aempty", 32'(almost_empty), 32'd0);
    for (int i = 0; i < 64; i++) rd_step(1'b1, "drain_data");
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_rcount0", 32'(r_count), 32'd0);
    repeat (5) @(posedge writeClock);
    #1;
    chk("drain_full0", 32'(full), 32'd0);
    chk("drain_wcount0", 32'(w_count), 32'd0);
    chk("ovf_hold", 32'(overflow), 32'd1);
    pulse_clr();
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Read while empty
    rd_step(1'b1, "udf_data");
    chk("udf_rdata_hold", 32'(r_data), 32'h3F);
    chk("udf_set", 32'(underflow), 32'd1);
    pulse_clr();
    chk("udf_clr", 32'(underflow), 32'd0);

    // Concurrent streaming with random enables
    nwr = 0;
    nread = 0;
    fork
      begin
        int cyc = 0;
        while (nwr < 500 && cyc < 20000) begin
          wr_step(1'($urandom_range(0, 1)), 8'($urandom));
          cyc++;
        end
      end
      begin
        int cyc = 0;
        while (nread < 500 && cyc < 20000) begin
          rd_step(1'($urandom_range(0, 1)), "stream_data");
          cyc++;
        end
      end
    join
    chk("stream_writes", 32'(nwr), 32'd500);
    chk("stream_reads", 32'(nread), 32'd500);
    chk("stream_full_ok", 32'(viol_full), 32'd0);
    chk("stream_empty_ok", 32'(viol_empty), 32'd0);

    // Reset mid-operation
    for (int i = 0; i < 20; i++) wr_step(1'b1, 8'(100 + i));
    wait_not_empty("mid_wait");
    for (int i = 0; i < 5; i++) rd_step(1'b1, "mid_data");
    #3;
    n_rst = 1'b0;
    sb.delete();
    #40;
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_full", 32'(full), 32'd0);
    @(negedge writeClock);
    #1;
    n_rst = 1'b1;
    repeat (2) @(posedge readClock);
    #1;
    chk("post_empty", 32'(empty), 32'd1);
    chk("post_rcount", 32'(r_count), 32'd0);
    chk("post_wcount", 32'(w_count), 32'd0);
    wr_step(1'b1, 8'h5A);
    repeat (6) @(posedge readClock);
    #1;
    chk("post_visible", 32'(empty), 32'd0);
`ifdef RX_FIFO_FWFT_EN
    chk("post_fwft_data", 32'(r_data), 32'h5A);
`endif
    rd_step(1'b1, "post_first");
    chk("post_empty_again", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_async_fifo.md
Name: rx_async_fifo

Overview:
- Parametrised dual-clock receive FIFO. Successor to the fixed 8-bit, 64-entry RX FIFO.
- Gray-coded pointers with multi-stage synchronisers. Depth is a power of two.
- Provides almost-full/almost-empty thresholds, per-domain fill counts and sticky overflow/underflow error flags.
- Sits between the bit-level receiver (write side, writeClock) and the consuming logic (read side, readClock).

Parameters:
- DATA_WIDTH, 8: width of w_data and r_data.
- ADDR_WIDTH, 6: address bits; depth DEPTH = 2**ADDR_WIDTH (default 64).
- AFULL_TH, 56: almost_full asserts when w_count >= AFULL_TH.
- AEMPTY_TH, 4: almost_empty asserts when r_count <= AEMPTY_TH.
- SYNC_STAGES, 2: flop stages per cross-domain pointer synchroniser; legal values 2..4.

Ports:
- readClock  in  1  read-domain clock.
- n_rst  in  1  asynchronous, active-low reset; clears both domains.
- writeClock  in  1  write-domain clock.
- w_enable  in  1  write request (writeClock).
- w_data  in  DATA_WIDTH  write data.
- full  out  1  FIFO full (writeClock view).
- almost_full  out  1  threshold flag (writeClock).
- w_count  out  ADDR_WIDTH+1  occupancy seen by the writer.
- overflow  out  1  sticky: write attempted while full.
- r_enable  in  1  read request (readClock).
- r_data  out  DATA_WIDTH  read data.
- empty  out  1  FIFO empty (readClock view).
- almost_empty  out  1  threshold flag (readClock).
- r_count  out  ADDR_WIDTH+1  occupancy seen by the reader.
- underflow  out  1  sticky: read attempted while empty.
- clr_err  in  1  clears overflow (sampled in writeClock domain) and underflow (sampled in readClock domain).

Behaviour:
- Reset: n_rst is asynchronous, active-low, clock readClock (plus writeClock for the write domain). While low, all pointers, synchronisers and error flags are 0.
- Output values during reset: r_data=0, empty=1, almost_empty=1, full=0, almost_full=0, both counts 0. Memory contents are not reset.
- Pointers: binary and Gray, both ADDR_WIDTH+1 bits. Gray = bin ^ (bin>>1). The MSB distinguishes wrap.
- Write: on writeClock edge with w_enable && !full, store mem[wbin[ADDR_WIDTH-1:0]] <= w_data and increment wbin. A write while full is dropped, memory is untouched, and overflow is set.
- Read (default mode): on readClock edge with r_enable && !empty, r_data <= mem[rbin[ADDR_WIDTH-1:0]] and rbin increments. Latency is 1 readClock cycle.
  - A read while empty leaves r_data holding its value and sets underflow.
- full: registered in the write domain. full = (wgray_next == {~rq_gray[MSB:MSB-1], rq_gray[MSB-2:0]}), where rq_gray is the synchronised read pointer.
- empty: registered in the read domain. empty = (rgray_next == wq_gray).
- Counts: w_count = wbin - gray2bin(rq_gray); r_count = gray2bin(wq_gray) - rbin. Both use modulo 2**(ADDR_WIDTH+1) arithmetic and are registered.
  - The remote pointer lags by SYNC_STAGES cycles, so both counts are conservative: w_count is never under-reported and r_count is never over-reported.
- Cross-domain latency:
  - A write becomes visible to the read side (empty deasserts) SYNC_STAGES+1 readClock edges after the write edge.
  - A read frees space on the write side after SYNC_STAGES+1 writeClock edges.
- Boundaries:
  - Exactly DEPTH writes with no reads sets full. The DEPTH+1th write is dropped.
  - Wrap-around at 2**ADDR_WIDTH is seamless; the MSB toggles.
  - Simultaneous read and write on a non-empty, non-full FIFO: both complete.
  - With a single entry, empty rises the same edge as the last read.
- Error flags: overflow and underflow hold until clr_err or reset. If set and clear happen on the same edge, set wins.
- Reset mid-operation: all in-flight data is discarded. After release the FIFO reads empty, and the first write lands at address 0.

Optional Feature:
- Macro RX_FIFO_FWFT_EN enables first-word-fall-through.
- Defined:
  - r_data presents the head word without a read request. An internal output-valid register is added.
  - empty reflects that register; r_enable pops the word shown and loads the next one, or clears valid.
  - The first word appears SYNC_STAGES+2 readClock edges after the write.
  - r_count includes the word held in the output register.
- Undefined: standard 1-cycle registered read as described in Behaviour.

Decomposition:
- Package rx_fifo_pkg:
  - bin2gray and gray2bin functions, parameterised via a width argument or a let/typedef.
  - Default constants RX_FIFO_DATA_W=8 and RX_FIFO_ADDR_W=6.
  - typedef ptr_t for (ADDR_WIDTH+1)-bit pointers.
- Sub-module fifo_ptr_sync: a SYNC_STAGES-deep flop chain that carries a Gray pointer into the destination clock. It has async n_rst and is instantiated twice.

Test Plan:
- Reset with writeClock=10ns and readClock=14ns -> empty=1, full=0, r_data=0, counts 0, overflow=0, underflow=0.
- Write 0x00..0x3F (64 words) with no reads -> full=1, w_count=64, almost_full rose at w_count=56. A 65th write of 0xAA -> dropped, overflow=1.
- Drain all 64 words -> r_data sequence 0x00..0x3F in order, empty=1 after the last read. Then pulse clr_err -> overflow=0.
- Read while empty -> r_data unchanged, underflow=1.
- Continuous concurrent streaming of 500 words with random enables -> data order preserved across many pointer wraps; full and empty never assert falsely.
- Assert n_rst after 20 writes and 5 reads -> after release, empty=1, r_count=0. Then write 0x5A -> 0x5A is read first. Repeat with RX_FIFO_FWFT_EN defined -> 0x5A appears on r_data without r_enable.
